// File: rtl/ascon_out_packer.sv
// ascon_out_packer: buffers the ascon core's free-running data and tag outputs and
// replays each message as one valid/ready stream: data words, then four tag words.
module ascon_out_packer #(
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [31:0]  in_data,
   input  logic [1:0]   in_type,
   input  logic         in_valid,
   input  logic         in_last,
   input  logic [127:0] tag_in,
   input  logic         tag_valid,
   output logic [31:0]  out_data,
   output logic [1:0]   out_type,
   output logic         out_tag,
   output logic         out_valid,
   input  logic         out_ready,
   output logic         out_last,
   output logic         err_overflow,
   output logic         err_tag,
   output logic         busy,
   output logic [1:0]   dbg_state
);

   localparam logic [1:0] TYPE_EMPTY = 2'd0;

   typedef enum logic [1:0] {
      S_DATA = 2'd0,
      S_WTAG = 2'd1,
      S_TAG  = 2'd2
   } state_t;

   // Handshake: a word transfers on a rising edge where out_valid && out_ready; while
   // stalled the presented word holds, and out_valid only falls after a transfer.

   state_t        state_q, state_d;
   logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [34:0]   mem [DEPTH];
   logic [34:0]   head;
   logic [127:0]  tag_reg_q, tag_reg_d;
   logic          tag_pend_q, tag_pend_d;
   logic          tag_empty_q, tag_empty_d;
   logic          seen_q, seen_d;
   logic          tv_prev_q, tv_prev_d;
   logic [1:0]    k_q, k_d;
   logic          err_ovf_q, err_ovf_d;
   logic          err_tag_q, err_tag_d;
   logic          fifo_empty, fifo_full;
   logic          push, pop, tag_rise, tag_cap, tag_done;

   always_comb begin
      fifo_empty = (wr_ptr_q == rd_ptr_q);
      fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
      head       = mem[rd_ptr_q[AW-1:0]];
   end

   // Read FSM and output mux.
   always_comb begin
      state_d   = state_q;
      k_d       = k_q;
      out_valid = 1'b0;
      out_data  = 32'd0;
      out_type  = 2'd0;
      out_tag   = 1'b0;
      out_last  = 1'b0;
      pop       = 1'b0;
      tag_done  = 1'b0;
      case (state_q)
         S_DATA: begin
            if (!fifo_empty) begin
               out_valid = 1'b1;
               out_data  = head[31:0];
               out_type  = head[34:33];
            end
            if (!fifo_empty && out_ready) begin
               pop = 1'b1;
               if (head[32]) state_d = tag_pend_q ? S_TAG : S_WTAG;
            end else if (fifo_empty && tag_pend_q && tag_empty_q) begin
               state_d = S_TAG;
            end
         end
         S_WTAG: begin
            if (tag_pend_q) state_d = S_TAG;
         end
         S_TAG: begin
            out_valid = 1'b1;
            out_tag   = 1'b1;
            out_type  = TYPE_EMPTY;
            out_last  = (k_q == 2'd3);
            case (k_q)
               2'd0:    out_data = tag_reg_q[127:96];
               2'd1:    out_data = tag_reg_q[95:64];
               2'd2:    out_data = tag_reg_q[63:32];
               default: out_data = tag_reg_q[31:0];
            endcase
            if (out_ready) begin
               if (k_q == 2'd3) begin
                  k_d      = 2'd0;
                  tag_done = 1'b1;
                  state_d  = S_DATA;
               end else begin
                  k_d = k_q + 2'd1;
               end
            end
         end
         default: state_d = S_DATA;
      endcase
   end

   // Write side and tag capture. A full FIFO still takes a word when the head pops.
   always_comb begin
      push      = in_valid && (!fifo_full || pop);
      wr_ptr_d  = push ? wr_ptr_q + {{AW{1'b0}}, 1'b1} : wr_ptr_q;
      rd_ptr_d  = pop ? rd_ptr_q + {{AW{1'b0}}, 1'b1} : rd_ptr_q;
      err_ovf_d = err_ovf_q | (in_valid && fifo_full && !pop);

      tag_rise  = tag_valid && !tv_prev_q;
      tag_cap   = tag_rise && !tag_pend_q;
      tv_prev_d = tag_valid;
      err_tag_d = err_tag_q | (tag_rise && tag_pend_q);
      tag_reg_d = tag_cap ? tag_in : tag_reg_q;
      tag_pend_d = tag_cap | (tag_pend_q & !tag_done);
      // A tag marks an empty message when nothing was pushed since the previous tag,
      // counting a push on the capture cycle itself as part of this message.
      tag_empty_d = tag_cap ? !(seen_q || in_valid) : tag_empty_q;
      seen_d      = tag_cap ? 1'b0 : (seen_q | in_valid);
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr_q[AW-1:0]] <= {in_type, in_last, in_data};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_DATA;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         tag_reg_q   <= '0;
         tag_pend_q  <= 1'b0;
         tag_empty_q <= 1'b0;
         seen_q      <= 1'b0;
         tv_prev_q   <= 1'b0;
         k_q         <= 2'd0;
         err_ovf_q   <= 1'b0;
         err_tag_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         tag_reg_q   <= tag_reg_d;
         tag_pend_q  <= tag_pend_d;
         tag_empty_q <= tag_empty_d;
         seen_q      <= seen_d;
         tv_prev_q   <= tv_prev_d;
         k_q         <= k_d;
         err_ovf_q   <= err_ovf_d;
         err_tag_q   <= err_tag_d;
      end
   end

   assign err_overflow = err_ovf_q;
   assign err_tag      = err_tag_q;
   assign busy         = !fifo_empty || tag_pend_q || (state_q != S_DATA);
   assign dbg_state    = state_q;

endmodule

// File: tb/tb_ascon_out_packer.sv
// Bench for ascon_out_packer: directed vector table, hand-written corner sequences and
// randomized messages checked against a message-level expected stream.
module tb_ascon_out_packer;

   localparam logic [1:0] TYPE_EMPTY = 2'd0;
   localparam logic [1:0] TYPE_PLAIN = 2'd1;
   localparam logic [127:0] TAG_BASIC = 128'h00112233_44556677_8899aabb_ccddeeff;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic [31:0]  in_data = '0;
   logic [1:0]   in_type = '0;
   logic         in_valid = 1'b0, in_last = 1'b0, tag_valid = 1'b0;
   logic [127:0] tag_in = '0;
   logic         out_ready = 1'b0;

   logic [31:0] out_data, o4_data;
   logic [1:0]  out_type, o4_type, dbg_state, o4_dbg;
   logic        out_tag, out_valid, out_last, err_overflow, err_tag, busy;
   logic        o4_tag, o4_valid, o4_last, o4_ovf, o4_etag, o4_busy;

   ascon_out_packer dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_type(in_type), .in_valid(in_valid),
      .in_last(in_last), .tag_in(tag_in), .tag_valid(tag_valid), .out_data(out_data),
      .out_type(out_type), .out_tag(out_tag), .out_valid(out_valid), .out_ready(out_ready),
      .out_last(out_last), .err_overflow(err_overflow), .err_tag(err_tag), .busy(busy),
      .dbg_state(dbg_state)
   );

   ascon_out_packer #(.DEPTH(4), .AW(2)) dut4 (
      .clk(clk), .rst(rst), .in_data(in_data), .in_type(in_type), .in_valid(in_valid),
      .in_last(in_last), .tag_in(tag_in), .tag_valid(tag_valid), .out_data(o4_data),
      .out_type(o4_type), .out_tag(o4_tag), .out_valid(o4_valid), .out_ready(out_ready),
      .out_last(o4_last), .err_overflow(o4_ovf), .err_tag(o4_etag), .busy(o4_busy),
      .dbg_state(o4_dbg)
   );

   int checks = 0;
   int failures = 0;
   logic [35:0] exp_q[$];

   task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   // out_ready driver: table pattern, random, or a forced level.
   int        rdy_mode = 2;
   logic      rdy_force = 1'b0;
   logic [15:0] rpat = 16'hffff;
   int        pcyc = 0;
   int        pat_origin = 0;
   always @(posedge clk) begin
      #2;
      case (rdy_mode)
         0:       out_ready = rpat[(pcyc - pat_origin) % 16];
         1:       out_ready = ($urandom_range(0, 3) != 0);
         default: out_ready = rdy_force;
      endcase
      pcyc++;
   end

   // Monitor: transfers against the expected stream, plus stall stability.
   bit          mon_en = 1'b1;
   bit          stall_prev = 1'b0;
   logic [35:0] stall_word, obs, expw;
   int          cyc = 0, obs_cnt = 0, first_cyc = 0, last_cyc = 0;
   logic [31:0] last_obs = '0;
   always @(negedge clk) begin
      cyc++;
      if (!rst || !mon_en) begin
         stall_prev = 1'b0;
      end else begin
         obs = {out_tag, out_last, out_type, out_data};
         if (stall_prev) begin
            checks++;
            if (!out_valid || obs !== stall_word) begin
               failures++;
               $display("FAIL stall_hold got=%0h/%0b exp=%0h/1", obs, out_valid, stall_word);
            end
         end
         if (out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL unexpected_word got=%0h exp=none", obs);
            end else begin
               expw = exp_q.pop_front();
               if (obs !== expw) begin
                  failures++;
                  $display("FAIL stream_word got=%0h exp=%0h", obs, expw);
               end
            end
            obs_cnt++;
            if (obs_cnt == 1) first_cyc = cyc;
            last_cyc = cyc;
            last_obs = out_data;
         end
         stall_prev = out_valid && !out_ready;
         stall_word = obs;
      end
   end

   task automatic push_tag_exp(input logic [127:0] tg);
      for (int i = 0; i < 4; i++)
         exp_q.push_back({1'b1, (i == 3), TYPE_EMPTY, tg[127 - 32*i -: 32]});
   endtask

   task automatic push_word(input logic [31:0] d, input logic [1:0] t, input logic l,
                            input logic with_tag, input logic [127:0] tg);
      in_data = d; in_type = t; in_last = l; in_valid = 1'b1;
      exp_q.push_back({1'b0, 1'b0, t, d});
      if (with_tag) begin
         tag_in = tg; tag_valid = 1'b1;
         push_tag_exp(tg);
      end
      @(posedge clk); #1;
      in_valid = 1'b0; in_last = 1'b0; tag_valid = 1'b0;
      if (with_tag) begin @(posedge clk); #1; end
   endtask

   task automatic pulse_tag(input logic [127:0] tg, input bit add_exp);
      tag_in = tg; tag_valid = 1'b1;
      if (add_exp) push_tag_exp(tg);
      @(posedge clk); #1;
      tag_valid = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic wait_prev(input int allowed);
      int n = 0;
      while (exp_q.size() > allowed && n < 3000) begin @(posedge clk); #1; n++; end
      if (exp_q.size() > allowed) begin
         checks++; failures++;
         $display("FAIL wait_timeout got=%0d exp=%0d", exp_q.size(), allowed);
         exp_q.delete();
      end
   endtask

   task automatic wait_drain();
      wait_prev(0);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
   endtask

   typedef struct {
      int               nw;
      logic [2:0][31:0] w;
      logic [1:0]       ty;
      logic [127:0]     tg;
      logic [15:0]      rpat;
      logic             twl;
      int               exp_cnt;
      logic [31:0]      exp_last;
      int               exp_span;
   } vec_t;

   function automatic vec_t mk(input int nw, input logic [95:0] w, input logic [1:0] ty,
                               input logic [127:0] tg, input logic [15:0] rp, input logic twl,
                               input int cnt, input logic [31:0] lst, input int span);
      vec_t v;
      v.nw = nw; v.w = w; v.ty = ty; v.tg = tg; v.rpat = rp; v.twl = twl;
      v.exp_cnt = cnt; v.exp_last = lst; v.exp_span = span;
      return v;
   endfunction

   vec_t vecs[6];

   task automatic run_vec(input vec_t v, input string nm);
      rdy_mode = 0; rpat = v.rpat; pat_origin = pcyc; obs_cnt = 0;
      for (int i = 0; i < v.nw; i++)
         push_word(v.w[i], v.ty, (i == v.nw - 1), v.twl && (i == v.nw - 1), v.tg);
      if (v.nw == 0 || !v.twl) pulse_tag(v.tg, 1'b1);
      wait_drain();
      repeat (2) begin @(posedge clk); #1; end
      chk({nm, "_count"}, obs_cnt, v.exp_cnt);
      chk({nm, "_last_word"}, last_obs, v.exp_last);
      if (v.exp_span != 0) chk({nm, "_span"}, last_cyc - first_cyc, v.exp_span);
      chk({nm, "_err_overflow"}, err_overflow, 0);
      chk({nm, "_err_tag"}, err_tag, 0);
      chk({nm, "_busy"}, busy, 0);
   endtask

   task automatic check_all_zero(input string nm);
      chk({nm, "_out_valid"}, out_valid, 0);
      chk({nm, "_out_data"}, out_data, 0);
      chk({nm, "_out_type"}, out_type, 0);
      chk({nm, "_out_tag"}, out_tag, 0);
      chk({nm, "_out_last"}, out_last, 0);
      chk({nm, "_errs"}, {err_overflow, err_tag}, 0);
      chk({nm, "_busy"}, busy, 0);
   endtask

   task automatic run_random(input int nmsg);
      int len, pushed;
      logic [1:0] ty;
      logic [127:0] tg;
      logic twl;
      rdy_mode = 1;
      for (int m = 0; m < nmsg; m++) begin
         len = $urandom_range(0, 7);
         tg = {$urandom(), $urandom(), $urandom(), $urandom()};
         twl = ($urandom_range(0, 1) == 1);
         pushed = 0;
         for (int i = 0; i < len; i++) begin
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            ty = 2'($urandom_range(0, 3));
            if (i == len - 1) wait_prev(pushed);
            push_word($urandom(), ty, (i == len - 1), twl && (i == len - 1), tg);
            pushed++;
         end
         if (len == 0 || !twl) begin
            wait_prev(pushed);
            pulse_tag(tg, 1'b1);
         end
      end
      wait_drain();
      repeat (3) begin @(posedge clk); #1; end
      chk("rand_err_overflow", err_overflow, 0);
      chk("rand_err_tag", err_tag, 0);
      chk("rand_busy", busy, 0);
   endtask

   logic [31:0] got4[$];

   initial begin
      vecs[0] = mk(2, {32'h0, 32'h6173636f, 32'h6e000000}, TYPE_PLAIN, TAG_BASIC,
                   16'hffff, 1'b0, 6, 32'hccddeeff, 0);
      vecs[1] = mk(2, {32'h0, 32'h6173636f, 32'h6e000000}, TYPE_PLAIN, TAG_BASIC,
                   16'hffff, 1'b1, 6, 32'hccddeeff, 5);
      vecs[2] = mk(2, {32'h0, 32'h6173636f, 32'h6e000000}, TYPE_PLAIN, TAG_BASIC,
                   16'h9999, 1'b0, 6, 32'hccddeeff, 0);
      vecs[3] = mk(3, {32'h89abcdef, 32'h01234567, 32'hdeadbeef}, 2'd2,
                   128'h0badf00d_11111111_22222222_33333333, 16'h5a5a, 1'b1, 7, 32'h33333333, 0);
      vecs[4] = mk(0, 96'h0, TYPE_PLAIN, 128'hfedcba98_76543210_0f1e2d3c_4b5a6978,
                   16'hffff, 1'b0, 4, 32'h4b5a6978, 3);
      vecs[5] = mk(1, {32'h0, 32'h0, 32'hcafe0001}, 2'd3,
                   128'h44444444_55555555_66666666_77777777, 16'h3333, 1'b1, 5, 32'h77777777, 0);

      // Reset state, with inputs active while reset is held.
      in_valid = 1'b1; tag_valid = 1'b1; in_data = 32'h12345678;
      #12;
      check_all_zero("reset");
      in_valid = 1'b0; tag_valid = 1'b0;
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1;

      foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

      // Tag arrives before the consumer starts draining.
      rdy_mode = 2; rdy_force = 1'b0; obs_cnt = 0;
      push_word(32'h00000a01, TYPE_PLAIN, 1'b0, 1'b0, '0);
      push_word(32'h00000a02, TYPE_PLAIN, 1'b0, 1'b0, '0);
      push_word(32'h00000a03, TYPE_PLAIN, 1'b1, 1'b0, '0);
      pulse_tag(TAG_BASIC, 1'b1);
      chk("predrain_busy", busy, 1);
      chk("predrain_head", {out_valid, out_data}, {1'b1, 32'h00000a01});
      rdy_force = 1'b1;
      wait_drain();
      chk("predrain_busy_fall", busy, 0);
      chk("predrain_count", obs_cnt, 7);

      // Empty message, then a second tag while the first is still pending.
      rdy_force = 1'b0; obs_cnt = 0;
      pulse_tag(128'habcdef01_23456789_13579bdf_02468ace, 1'b1);
      chk("empty_first_word", {out_valid, out_tag, out_last, out_data},
          {3'b110, 32'habcdef01});
      chk("empty_err_tag_before", err_tag, 0);
      pulse_tag(128'h99999999_88888888_77777777_66666666, 1'b0);
      chk("empty_err_tag_after", err_tag, 1);
      rdy_force = 1'b1;
      wait_drain();
      repeat (4) begin @(posedge clk); #1; end
      chk("empty_count", obs_cnt, 4);
      chk("empty_last_word", last_obs, 32'h02468ace);
      chk("empty_err_tag_sticky", err_tag, 1);
      do_reset();

      // Asynchronous reset while tag word 2 is presented.
      rdy_force = 1'b0;
      push_word(32'h6e000000, TYPE_PLAIN, 1'b0, 1'b0, '0);
      push_word(32'h6173636f, TYPE_PLAIN, 1'b1, 1'b0, '0);
      pulse_tag(TAG_BASIC, 1'b1);
      rdy_force = 1'b1;
      repeat (3) @(posedge clk);
      #1 rdy_force = 1'b0;
      @(posedge clk); #1;
      chk("midtag_word2", {out_valid, out_tag, out_data}, {2'b11, 32'h44556677});
      #2 rst = 1'b0;
      #1;
      check_all_zero("midtag_reset");
      exp_q.delete();
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1;
      run_vec(vecs[0], "after_reset");

      // Overflow on the 4-deep instance.
      mon_en = 1'b0; rdy_mode = 2; rdy_force = 1'b0;
      for (int i = 1; i <= 4; i++) push_word(32'(i), TYPE_PLAIN, 1'b0, 1'b0, '0);
      chk("ovf_before", o4_ovf, 0);
      push_word(32'd5, TYPE_PLAIN, 1'b0, 1'b0, '0);
      chk("ovf_after", o4_ovf, 1);
      chk("ovf_head", {o4_valid, o4_data}, {1'b1, 32'd1});
      chk("ovf_deep_fifo_clean", err_overflow, 0);
      rdy_force = 1'b1;
      got4.delete();
      repeat (12) begin
         @(negedge clk);
         if (o4_valid && out_ready) got4.push_back(o4_data);
      end
      chk("ovf_count", got4.size(), 4);
      for (int i = 0; i < got4.size(); i++) chk($sformatf("ovf_word%0d", i), got4[i], i + 1);
      chk("ovf_sticky", o4_ovf, 1);
      do_reset();
      mon_en = 1'b1;

      run_random(40);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      failures++;
      $display("FAIL watchdog got=timeout exp=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
